// File: rtl/md5_hbf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : md5_hbf_pkg                                            |
// | Description : Shared constants and state encodings for the MD5       |
// |               target-hash command receiver.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package md5_hbf_pkg;

   localparam logic [7:0] HDR_BYTE     = 8'h55;
   localparam int         HASH_BYTES   = 16;
   localparam int         TIMEOUT_BITS = 256;

   // Bit-level receiver states
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Frame parser states
   typedef enum logic [1:0] {
      P_HDR  = 2'd0,
      P_DATA = 2'd1,
      P_SUM  = 2'd2
   } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx_core                                           |
// | Description : 8N1 UART receiver. Two-flop input synchroniser, start  |
// |               glitch rejection, mid-bit sampling, one-cycle strobe   |
// |               per good byte and one-cycle frame_err on a 0 stop bit. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_rx_core #(
   parameter int DIV = 138
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       strobe,
   output logic       frame_err
);
   import md5_hbf_pkg::*;

   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_prev;
   rx_state_t     r_state;
   rx_state_t     w_next;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [7:0]    r_byte;
   logic          r_strobe;
   logic          r_ferr;
   logic          w_line;
   logic          w_half;
   logic          w_full;

   assign w_line = r_sync2;
   assign w_half = (r_cnt == CW'(HALF - 1));
   assign w_full = (r_cnt == CW'(DIV - 1));

   // Synchronise the serial line; idle-high reset value avoids a false start edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Receiver state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= RX_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; IDLE re-arms only on a high-to-low edge, so after a
   // bad stop bit the line must return high before the next byte is seen
   always_comb begin
      w_next = r_state;
      case (r_state)
         RX_IDLE:  if (r_prev && !w_line)         w_next = RX_START;
         RX_START: if (w_half)                    w_next = w_line ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_full && (r_bit == 3'd7)) w_next = RX_STOP;
         RX_STOP:  if (w_full)                    w_next = RX_IDLE;
         default:                                 w_next = RX_IDLE;
      endcase
   end

   // Bit timing, LSB-first shift register and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_byte   <= '0;
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
         if ((r_state == RX_IDLE) || ((r_state == RX_START) && w_half) || w_full) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if ((r_state == RX_START) && w_half) begin
            r_bit <= '0;
         end
         if ((r_state == RX_DATA) && w_full) begin
            r_shift <= {w_line, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
         end
         if ((r_state == RX_STOP) && w_full) begin
            if (w_line) begin
               r_byte   <= r_shift;
               r_strobe <= 1'b1;
            end else begin
               r_ferr   <= 1'b1;
            end
         end
      end
   end

   assign byte_out  = r_byte;
   assign strobe    = r_strobe;
   assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/hash_cmd_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hash_cmd_receiver                                      |
// | Description : Receives MD5 target-hash frames over UART:             |
// |               0x55 header, 16 payload bytes (byte 0 -> [127:120]),   |
// |               optional XOR checksum. Aborts on inter-byte timeout    |
// |               or framing error mid-frame.                            |
// | Options     : define HASH_CMD_CHECKSUM_EN to expect the checksum     |
// |               byte after the payload.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hash_cmd_receiver #(
   parameter int clock_freq = 16000000,
   parameter int baud_rate  = 115200
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         uart_in,
   output logic [7:0]   rx_byte,
   output logic         rx_strobe,
   output logic [127:0] target_hash,
   output logic         hash_strobe,
   output logic         hash_valid,
   output logic         cmd_error
);
   import md5_hbf_pkg::*;

   localparam int DIV    = clock_freq / baud_rate;
   localparam int TO_CYC = TIMEOUT_BITS * DIV;
   localparam int TOW    = $clog2(TO_CYC + 1);
   localparam int IDXW   = $clog2(HASH_BYTES);
`ifdef HASH_CMD_CHECKSUM_EN
   // Whole payload sits in the shadow before the checksum byte arrives
   localparam int SHW    = 8 * HASH_BYTES;
`else
   // Last payload byte is taken straight from the receiver on accept
   localparam int SHW    = 8 * (HASH_BYTES - 1);
`endif

   logic [7:0]      w_byte;
   logic            w_strb;
   logic            w_ferr;

   parse_state_t    r_pstate;
   parse_state_t    w_pnext;
   logic [IDXW-1:0] r_idx;
   logic [SHW-1:0]  r_shadow;
   logic [TOW-1:0]  r_to_cnt;
   logic [127:0]    r_target;
   logic            r_hash_strobe;
   logic            r_hash_valid;
   logic            r_cmd_error;
   logic            w_timeout;
   logic            w_start;
   logic            w_shift;
   logic            w_accept;
   logic            w_err;
`ifdef HASH_CMD_CHECKSUM_EN
   logic [7:0]      r_sum;
   logic            w_sum_ok;

   assign w_sum_ok = (w_byte == r_sum);
`endif

   uart_rx_core #(
      .DIV(DIV)
   ) u_rx (
      .clock    (clock),
      .reset    (reset),
      .rx       (uart_in),
      .byte_out (w_byte),
      .strobe   (w_strb),
      .frame_err(w_ferr)
   );

   assign w_timeout = (r_to_cnt == TOW'(TO_CYC));

   // Parser next-state and control; 0x55 in the payload is ordinary data
   always_comb begin
      w_pnext  = r_pstate;
      w_start  = 1'b0;
      w_shift  = 1'b0;
      w_accept = 1'b0;
      w_err    = w_ferr;
      case (r_pstate)
         P_HDR: begin
            if (w_strb && (w_byte == HDR_BYTE)) begin
               w_pnext = P_DATA;
               w_start = 1'b1;
            end
         end
         P_DATA: begin
            if (w_ferr || w_timeout) begin
               w_err   = 1'b1;
               w_pnext = P_HDR;
            end else if (w_strb) begin
               w_shift = 1'b1;
               if (r_idx == IDXW'(HASH_BYTES - 1)) begin
`ifdef HASH_CMD_CHECKSUM_EN
                  w_pnext  = P_SUM;
`else
                  w_accept = 1'b1;
                  w_pnext  = P_HDR;
`endif
               end
            end
         end
`ifdef HASH_CMD_CHECKSUM_EN
         P_SUM: begin
            if (w_ferr || w_timeout) begin
               w_err   = 1'b1;
               w_pnext = P_HDR;
            end else if (w_strb) begin
               w_pnext = P_HDR;
               if (w_sum_ok) begin
                  w_accept = 1'b1;
               end else begin
                  w_err    = 1'b1;
               end
            end
         end
`endif
         default: w_pnext = P_HDR;
      endcase
   end

   // Parser state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pstate <= P_HDR;
      end else begin
         r_pstate <= w_pnext;
      end
   end

   // Inter-byte silence counter, active only while a frame is open
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_to_cnt <= '0;
      end else if ((r_pstate == P_HDR) || w_strb) begin
         r_to_cnt <= '0;
      end else if (!w_timeout) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   // Payload shadow, checksum accumulation and accepted-target outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_idx         <= '0;
         r_shadow      <= '0;
         r_target      <= '0;
         r_hash_strobe <= 1'b0;
         r_hash_valid  <= 1'b0;
         r_cmd_error   <= 1'b0;
`ifdef HASH_CMD_CHECKSUM_EN
         r_sum         <= '0;
`endif
      end else begin
         r_hash_strobe <= 1'b0;
         r_cmd_error   <= w_err;
         if (w_start) begin
            r_idx <= '0;
`ifdef HASH_CMD_CHECKSUM_EN
            r_sum <= HDR_BYTE;
`endif
         end
         if (w_shift) begin
            r_shadow <= {r_shadow[SHW-9:0], w_byte};
            r_idx    <= r_idx + 1'b1;
`ifdef HASH_CMD_CHECKSUM_EN
            r_sum    <= r_sum ^ w_byte;
`endif
         end
         if (w_accept) begin
`ifdef HASH_CMD_CHECKSUM_EN
            r_target <= r_shadow;
`else
            r_target <= {r_shadow, w_byte};
`endif
            r_hash_strobe <= 1'b1;
            r_hash_valid  <= 1'b1;
         end
      end
   end

   assign rx_byte     = w_byte;
   assign rx_strobe   = w_strb;
   assign target_hash = r_target;
   assign hash_strobe = r_hash_strobe;
   assign hash_valid  = r_hash_valid;
   assign cmd_error   = r_cmd_error;

endmodule
`default_nettype wire

// File: tb/tb_hash_cmd_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_hash_cmd_receiver                                   |
// | Description : Self-checking bench for hash_cmd_receiver. Honours     |
// |               HASH_CMD_CHECKSUM_EN the same way as the design.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_hash_cmd_receiver;

   localparam int CLK_HZ    = 1600000;
   localparam int BAUD      = 115200;
   localparam int DIV       = CLK_HZ / BAUD;
   localparam int IDLE_BITS = 300;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic         uart_in = 1'b1;
   logic [7:0]   rx_byte;
   logic         rx_strobe;
   logic [127:0] target_hash;
   logic         hash_strobe;
   logic         hash_valid;
   logic         cmd_error;

   hash_cmd_receiver #(
      .clock_freq(CLK_HZ),
      .baud_rate (BAUD)
   ) dut (
      .clock      (clk),
      .reset      (rst_n),
      .uart_in    (uart_in),
      .rx_byte    (rx_byte),
      .rx_strobe  (rx_strobe),
      .target_hash(target_hash),
      .hash_strobe(hash_strobe),
      .hash_valid (hash_valid),
      .cmd_error  (cmd_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_rx   = 0;
   int n_hs   = 0;
   int n_err  = 0;
   int last_rx_cyc = 0;
   int last_hs_cyc = 0;

   always @(posedge clk) cyc++;

   // Pulse monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rx_strobe)   begin n_rx++; last_rx_cyc = cyc; end
      if (hash_strobe) begin n_hs++; last_hs_cyc = cyc; end
      if (cmd_error)   n_err++;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_ok, input int gap_bits);
      uart_in = 1'b0;
      wait_clk(DIV);
      for (int i = 0; i < 8; i++) begin
         uart_in = d[i];
         wait_clk(DIV);
      end
      uart_in = stop_ok;
      wait_clk(DIV);
      uart_in = 1'b1;
      wait_clk(gap_bits * DIV);
   endtask

   // Header, 16 payload bytes (byte 0 from [127:120]) and, when enabled,
   // the XOR checksum (or 0x00 when bad_sum is set)
   task automatic send_frame(input logic [127:0] h, input logic bad_sum);
      logic [7:0] s;
      logic [7:0] b;
      s = 8'h55;
      send_byte(8'h55, 1'b1, 1);
      for (int i = 0; i < 16; i++) begin
         b = h[127-8*i -: 8];
         s = s ^ b;
         send_byte(b, 1'b1, 1);
      end
`ifdef HASH_CMD_CHECKSUM_EN
      send_byte(bad_sum ? 8'h00 : s, 1'b1, 1);
`else
      if (bad_sum) s = 8'h00;
`endif
      wait_clk(2 * DIV);
   endtask

   // ---------------- Byte-stream reference model ----------------
   typedef struct {
      logic [7:0] d;
      logic       ok;
   } ev_t;

   ev_t          evq[$];
   logic [127:0] m_target;
   logic         m_valid;
   int           m_hs, m_err, m_rx, m_cnt;
   bit           m_in;
   logic [7:0]   m_pay[16];
   logic [7:0]   m_sum;

   task automatic model_accept();
      for (int i = 0; i < 16; i++) m_target[127-8*i -: 8] = m_pay[i];
      m_valid = 1'b1;
      m_hs++;
      m_in = 1'b0;
   endtask

   task automatic model_byte(input ev_t e);
      if (!e.ok) begin
         m_err++;
         m_in = 1'b0;
      end else begin
         m_rx++;
         if (!m_in) begin
            if (e.d == 8'h55) begin
               m_in  = 1'b1;
               m_cnt = 0;
               m_sum = 8'h55;
            end
         end else if (m_cnt < 16) begin
            m_pay[m_cnt] = e.d;
            m_sum = m_sum ^ e.d;
            m_cnt++;
`ifndef HASH_CMD_CHECKSUM_EN
            if (m_cnt == 16) model_accept();
`endif
         end else begin
            if (e.d == m_sum) model_accept();
            else begin m_err++; m_in = 1'b0; end
         end
      end
   endtask

   // ---------------- Single-byte vector table ----------------
   typedef struct {
      logic [7:0] d;
      logic       ok;
      logic [7:0] exp_byte;
      int         exp_rx;
      int         exp_err;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int           rx0, hs0, err0, t0, lat;
      logic [127:0] exp_target;
      logic [127:0] h;
      logic [7:0]   b, s;

      tbl[0] = '{8'hA3, 1'b1, 8'hA3, 1, 0};
      tbl[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
      tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
      tbl[3] = '{8'h7E, 1'b0, 8'hFF, 0, 1};
      tbl[4] = '{8'h81, 1'b1, 8'h81, 1, 0};
      tbl[5] = '{8'hAA, 1'b1, 8'hAA, 1, 0};

      // Reset state
      wait_clk(3);
      check("rst_rx_byte",     rx_byte,     8'h00);
      check("rst_rx_strobe",   rx_strobe,   1'b0);
      check("rst_target_hash", target_hash, 128'h0);
      check("rst_hash_strobe", hash_strobe, 1'b0);
      check("rst_hash_valid",  hash_valid,  1'b0);
      check("rst_cmd_error",   cmd_error,   1'b0);
      rst_n = 1'b1;
      wait_clk(4);

      // Single byte 0xA3 and its latency from the start edge
      rx0 = n_rx; t0 = cyc;
      send_byte(8'hA3, 1'b1, 2);
      lat = last_rx_cyc - t0;
      check("a3_strobes", n_rx - rx0, 1);
      check("a3_byte", rx_byte, 8'hA3);
      check("a3_latency_in_window", (lat >= 9 * DIV && lat <= 10 * DIV), 1'b1);

      // 0.3-bit low glitch
      rx0 = n_rx; err0 = n_err;
      uart_in = 1'b0;
      wait_clk((DIV * 3) / 10);
      uart_in = 1'b1;
      wait_clk(3 * DIV);
      check("glitch_no_strobe", n_rx - rx0, 0);
      check("glitch_no_error", n_err - err0, 0);

      // Table of isolated bytes while the parser hunts for a header
      for (int i = 0; i < 6; i++) begin
         rx0 = n_rx; err0 = n_err;
         send_byte(tbl[i].d, tbl[i].ok, 2);
         check($sformatf("tbl%0d_strobes", i), n_rx - rx0, tbl[i].exp_rx);
         check($sformatf("tbl%0d_errors", i), n_err - err0, tbl[i].exp_err);
         check($sformatf("tbl%0d_byte", i), rx_byte, tbl[i].exp_byte);
      end

      // Valid frame 00..0F
      exp_target = 128'h000102030405060708090A0B0C0D0E0F;
      hs0 = n_hs; err0 = n_err;
      send_frame(exp_target, 1'b0);
      check("frame1_target", target_hash, exp_target);
      check("frame1_valid", hash_valid, 1'b1);
      check("frame1_hash_strobes", n_hs - hs0, 1);
      check("frame1_no_error", n_err - err0, 0);
      check("frame1_strobe_lag", last_hs_cyc - last_rx_cyc, 1);

`ifdef HASH_CMD_CHECKSUM_EN
      // Same frame with wrong checksum
      hs0 = n_hs; err0 = n_err;
      send_frame(128'h000102030405060708090A0B0C0D0E0F, 1'b1);
      check("badsum_error", n_err - err0, 1);
      check("badsum_no_hash_strobe", n_hs - hs0, 0);
      check("badsum_target_kept", target_hash, exp_target);
      check("badsum_valid_kept", hash_valid, 1'b1);
`endif

      // Header + 5 payload bytes, then long silence
      err0 = n_err; hs0 = n_hs;
      send_byte(8'h55, 1'b1, 1);
      for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1, 1);
      wait_clk(IDLE_BITS * DIV);
      check("timeout_error", n_err - err0, 1);
      check("timeout_target_kept", target_hash, exp_target);
      check("timeout_no_hash_strobe", n_hs - hs0, 0);
      exp_target = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
      send_frame(exp_target, 1'b0);
      check("after_timeout_target", target_hash, exp_target);
      check("after_timeout_hash_strobes", n_hs - hs0, 1);

      // Reset in the middle of a payload byte
      send_byte(8'h55, 1'b1, 1);
      send_byte(8'h11, 1'b1, 1);
      send_byte(8'h22, 1'b1, 1);
      send_byte(8'h33, 1'b1, 1);
      uart_in = 1'b0;
      wait_clk(20);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_rx_byte",     rx_byte,     8'h00);
      check("midrst_rx_strobe",   rx_strobe,   1'b0);
      check("midrst_target_hash", target_hash, 128'h0);
      check("midrst_hash_strobe", hash_strobe, 1'b0);
      check("midrst_hash_valid",  hash_valid,  1'b0);
      check("midrst_cmd_error",   cmd_error,   1'b0);
      @(negedge clk);
      uart_in = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2 * DIV);
      hs0 = n_hs; err0 = n_err;
      exp_target = 128'h00112233445566778899AABBCCDDEEFF;
      send_frame(exp_target, 1'b0);
      check("postrst_target", target_hash, exp_target);
      check("postrst_valid", hash_valid, 1'b1);
      check("postrst_hash_strobes", n_hs - hs0, 1);
      check("postrst_no_error", n_err - err0, 0);

      // Randomised byte streams against the reference model
      m_target = exp_target;
      m_valid  = 1'b1;
      m_in     = 1'b0;
      for (int t = 0; t < 6; t++) begin
         evq.delete();
         for (int j = 0; j < int'($urandom_range(0, 2)); j++)
            evq.push_back('{8'($urandom), ($urandom_range(0, 6) != 0)});
         h = {$urandom(), $urandom(), $urandom(), $urandom()};
         evq.push_back('{8'h55, 1'b1});
         s = 8'h55;
         for (int i = 0; i < 16; i++) begin
            b = h[127-8*i -: 8];
            if ($urandom_range(0, 4) == 0) b = 8'h55;
            if ($urandom_range(0, 39) == 0) evq.push_back('{8'($urandom), 1'b0});
            s = s ^ b;
            evq.push_back('{b, 1'b1});
         end
`ifdef HASH_CMD_CHECKSUM_EN
         if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
         evq.push_back('{s, 1'b1});
`endif
         m_hs = 0; m_err = 0; m_rx = 0;
         rx0 = n_rx; hs0 = n_hs; err0 = n_err;
         foreach (evq[k]) begin
            send_byte(evq[k].d, evq[k].ok, 1);
            model_byte(evq[k]);
         end
         if (m_in) begin
            wait_clk(IDLE_BITS * DIV);
            m_err++;
            m_in = 1'b0;
         end else begin
            wait_clk(2 * DIV);
         end
         check($sformatf("rnd%0d_target", t), target_hash, m_target);
         check($sformatf("rnd%0d_valid", t), hash_valid, m_valid);
         check($sformatf("rnd%0d_hash_strobes", t), n_hs - hs0, m_hs);
         check($sformatf("rnd%0d_errors", t), n_err - err0, m_err);
         check($sformatf("rnd%0d_rx_strobes", t), n_rx - rx0, m_rx);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
